id_hazard_unit: RTL

ID_HAZARD_UNIT -- requirements
Module: id_hazard_unit

---
 rtl/id_hazard_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/id_hazard_unit.sv
// Purpose : ID-stage hazard detection with a scoreboard of in-flight GPR/HI-LO writers and forward selection.
// Latency : stallreq and fwd_sel are combinational from ID inputs and scoreboard state (zero cycles).
// Backpr. : stallreq holds ID/IF and bubbles EX; the scoreboard only moves when pipe_adv is high.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   id_valid, pipe_adv     ID holds an instruction / downstream pipeline advances this cycle
//   flush                  kill the ID instruction (no stall, bubble enters EX)
//   src_addr, src_used     NUM_SRC packed 5-bit source registers and their read enables
//   dst_we/addr/is_load    GPR write of the ID instruction
//   hilo_rd, hilo_we       HI/LO read/write of the ID instruction
//   muldiv_busy            multi-cycle mult/div unit in EX is busy
//   stallreq               hazard stall request
//   fwd_sel                per source: 0 = regfile, k+1 = forward from stage k (0 = EX)
//   stall_cnt              stall-cycle counter; built only with ID_HAZARD_PERF_EN, else tied to 0
module id_hazard_unit #(
    parameter int NSTAGE   = 3,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    localparam int FWD_W   = $clog2(NSTAGE + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     id_valid,
    input  logic                     pipe_adv,
    input  logic                     flush,
    input  logic [NUM_SRC*5-1:0]     src_addr,
    input  logic [NUM_SRC-1:0]       src_used,
    input  logic                     dst_we,
    input  logic [4:0]               dst_addr,
    input  logic                     dst_is_load,
    input  logic                     hilo_rd,
    input  logic                     hilo_we,
    input  logic                     muldiv_busy,
    output logic                     stallreq,
    output logic [NUM_SRC*FWD_W-1:0] fwd_sel,
    output logic [31:0]              stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] addr;
        logic       is_load;
        logic       hilo_we;
    } sb_entry_t;

    // sb[0] is the youngest in-flight instruction (EX), sb[NSTAGE-1] the oldest (WB).
    sb_entry_t sb [NSTAGE];
    sb_entry_t new_entry;

    logic load_hazard;
    logic hilo_pending;
    logic hilo_hazard;

    // Entry captured into EX on advance. Stalled or flushed instructions enter
    // as an all-zero bubble so stale fields can never produce a match.
    always_comb begin
        new_entry = '0;
        if (id_valid && !stallreq && !flush) begin
            new_entry.valid   = 1'b1;
            new_entry.we      = dst_we;
            new_entry.addr    = dst_addr;
            new_entry.is_load = dst_is_load;
            new_entry.hilo_we = hilo_we;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NSTAGE; k++) begin
                sb[k] <= '0;
            end
        end else if (pipe_adv) begin
            sb[0] <= new_entry;
            for (int k = 1; k < NSTAGE; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    // Forward select: scan oldest to youngest so the youngest match is the
    // last one written. The load-use check follows the same youngest match,
    // since an older load shadowed by a younger ALU writer is not a hazard.
    always_comb begin
        fwd_sel     = '0;
        load_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic youngest_is_early_load;
            youngest_is_early_load = 1'b0;
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (src_used[i] && (src_addr[5*i +: 5] != 5'd0) &&
                    sb[k].valid && sb[k].we && (sb[k].addr == src_addr[5*i +: 5])) begin
                    fwd_sel[FWD_W*i +: FWD_W] = FWD_W'(k + 1);
                    youngest_is_early_load    = sb[k].is_load && (k < LOAD_LAT);
                end
            end
            load_hazard = load_hazard | youngest_is_early_load;
        end
    end

    always_comb begin
        hilo_pending = 1'b0;
        for (int k = 0; k < NSTAGE; k++) begin
            hilo_pending = hilo_pending | (sb[k].valid & sb[k].hilo_we);
        end
    end

    assign hilo_hazard = hilo_rd & (muldiv_busy | hilo_pending);

    // resetn gates the request so a stall drops the instant reset asserts,
    // even if muldiv_busy is still high.
    assign stallreq = resetn & id_valid & ~flush & (load_hazard | hilo_hazard);

`ifdef ID_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (stallreq && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
